uart_rx_stream: RTL and testbench
=================================

# uart_rx_stream

Receives 8N1 asynchronous serial data from the pico-ice UART RX pin (ICE_27) and presents the received bytes as a buffered valid/ready byte stream. It sits directly upstream of the PipelineC-generated top, in the same PLL clock domain, and replaces the ad-hoc deserialization previously done inside the PipelineC logic. The block synchronizes the raw pin, detects start bits, samples at mid-bit, checks the stop bit, and queues bytes in a small FIFO.

## Interface
- CLK_HZ, 25125000 — frequency of pll_clk in Hz
- BAUD, 115200 — serial bit rate
- FIFO_DEPTH, 4 — byte FIFO entries; power of two, ≥2
- CLKS_PER_BIT (derived, localparam) = (CLK_HZ + BAUD/2) / BAUD; elaboration error if < 4

- pll_clk  in  1  sole clock; all state is in this domain
- rst  in  1  reset, asynchronous and active-high
- rx_i  in  1  raw UART RX pin, asynchronous; idles high
- data_o  out  8  byte at the FIFO head
- valid_o  out  1  FIFO non-empty; data_o is valid
- ready_i  in  1  consumer accepts the head when valid_o && ready_i
- busy_o  out  1  receiver is in any state other than IDLE
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overflow_o  out  1  one-cycle pulse: completed byte dropped because the FIFO was full

## Operation
- Synchronizer: 2-flop chain on rx_i with reset value 1. rx_s is the output of the second flop. All decisions use rx_s only.
- Bit counter cnt counts from 0 to CLKS_PER_BIT−1. Bit index idx runs 0..7.
- FSM states and transitions:
  - IDLE: when rx_s==0, go to START and set cnt=0.
  - START: when cnt==CLKS_PER_BIT/2−1, sample rx_s. If 1, this is a glitch: return to IDLE with no output. If 0, go to DATA with cnt=0 and idx=0.
  - DATA: when cnt==CLKS_PER_BIT−1, shift rx_s into the shift register, LSB first, and reset cnt. After idx==7 is sampled, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT−1, sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse frame_err_o, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- FIFO push:
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow_o pulses. Contents already in the FIFO are never overwritten.
- FIFO pop: occurs on valid_o && ready_i. A pop and a push in the same cycle leave the count unchanged.
- data_o is driven from the head entry and is stable while valid_o=1 and ready_i=0.
- Reset values: FSM=IDLE, cnt=0, idx=0, FIFO empty, data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overflow_o=0.
- Reset asserted mid-frame aborts the frame. No output pulses occur. After release, the block waits in IDLE for the next falling edge. If the line is low at release, this starts a frame, which the START check rejects unless the line is still low at mid-start.

## Timing
- Input-to-FSM latency: 2 cycles through the synchronizer.
- Mid-bit sample points, with t0 = the cycle the FSM enters START:
  - start check at t0 + CLKS_PER_BIT/2
  - data bit k at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - stop bit at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- The push is registered. valid_o rises on the cycle after the stop-bit sample.
- frame_err_o and overflow_o pulse on that same cycle. Each is high for exactly 1 cycle.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start bit immediately following the stop bit is detected.
- Tolerance: about ±4% baud mismatch with CLKS_PER_BIT ≥ 8.
- Throughput: 1 byte per pop per cycle when the consumer is ready.

## Test plan
- Bench parameters: CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10.
- Single byte: send 0xA5 with ready_i=1 → valid_o for exactly 1 cycle with data_o=0xA5, 2+5+90+1 cycles after the rx_i falling edge; no error pulses.
- Back-to-back with backpressure: send 0x00, 0xFF, 0x3C, 0x81, 0x55 with no idle gap and ready_i=0 → FIFO holds 00, FF, 3C, 81; overflow_o pulses once at the 5th stop sample. Then raise ready_i → bytes pop in order; valid_o drops after 4 pops.
- Framing error: send 0x12 with the stop bit low, then hold low for 30 bits → exactly one frame_err_o pulse, no push, busy_o=1 until rx_i returns high. A following 0x34 is received correctly.
- Glitch rejection: 3-cycle low pulse on an idle line → no push, no frame_err_o; busy_o returns to 0 at the start check.
- Simultaneous push/pop at full: FIFO full, ready_i=1 on the cycle of the new push → push accepted, no overflow_o, count stays 4.
- Reset mid-frame: assert rst at data bit 4 of 0x77 → outputs zero immediately; no byte appears. The next 0x99 is received correctly.

Source files
------------

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM with
// stop-bit check, and a small byte FIFO presented as a valid/ready stream.
module uart_rx_stream #(
   parameter int CLK_HZ     = 25125000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       pll_clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overflow_o
);

   localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_stream: CLKS_PER_BIT must be at least 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_stream: FIFO_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic             rx_meta;
   logic             rx_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shift;
   logic             push_req;
   logic             ferr_req;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             pop;
   logic             full;
   logic             accept;

   // Idle-high reset value keeps a reset release from looking like a start bit.
   always_ff @(posedge pll_clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   // NOTE: every register in a clocked block uses <= so all of them update
   // from the same pre-edge values, regardless of statement order.
   always_ff @(posedge pll_clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         shift    <= '0;
         busy_o   <= 1'b0;
         push_req <= 1'b0;
         ferr_req <= 1'b0;
      end else begin
         push_req <= 1'b0;
         ferr_req <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state  <= S_START;
                  cnt    <= '0;
                  busy_o <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == CNT_MID) begin
                  cnt <= '0;
                  idx <= '0;
                  if (rx_s) begin
                     state  <= S_IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               // Leaving at mid-stop gives half a bit of slack to catch a
               // start bit that directly follows.
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     push_req <= 1'b1;
                     state    <= S_IDLE;
                     busy_o   <= 1'b0;
                  end else begin
                     ferr_req <= 1'b1;
                     state    <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   assign pop    = valid_o & ready_i;
   assign full   = (count == CNT_FULL);
   assign accept = push_req & (~full | pop);

   always_comb begin
      count_next = count;
      if (accept && !pop) begin
         count_next = count + (PTR_W + 1)'(1);
      end else if (!accept && pop) begin
         count_next = count - (PTR_W + 1)'(1);
      end
   end

   // NOTE: the storage array has no reset; data_o is masked while the FIFO is
   // empty, so stale or uninitialised entries are never visible.
   always_ff @(posedge pll_clk) begin
      if (accept) begin
         mem[wr_ptr] <= shift;
      end
   end

   always_ff @(posedge pll_clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overflow_o  <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count       <= count_next;
         valid_o     <= (count_next != '0);
         frame_err_o <= ferr_req;
         overflow_o  <= push_req & ~accept;
      end
   end

   assign data_o = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: serial frames are driven bit by bit, the
// expected bytes go into a scoreboard queue and are compared on each pop.
module tb_uart_rx_stream;

   localparam int CLK_HZ     = 1000000;
   localparam int BAUD       = 100000;
   localparam int FIFO_DEPTH = 4;
   localparam int CPB        = 10;
   // Cycles from the first edge that samples the falling start edge until
   // valid_o is high: synchronizer, half start bit, nine bits, push register.
   localparam int LAT        = 2 + CPB / 2 + 9 * CPB + 1;

   logic       pll_clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       busy_o;
   logic       frame_err_o;
   logic       overflow_o;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int n_ferr = 0;
   int n_ovf = 0;
   int n_valid = 0;
   int n_pop = 0;
   int rise_cyc = 0;
   int fall_cyc = 0;
   int s_ferr, s_ovf, s_valid, s_pop;
   int exp_v;
   logic valid_prev = 1'b0;
   logic [7:0] exp_q [$];

   uart_rx_stream #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .pll_clk    (pll_clk),
      .rst        (rst),
      .rx_i       (rx_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .busy_o     (busy_o),
      .frame_err_o(frame_err_o),
      .overflow_o (overflow_o)
   );

   always #5 pll_clk = ~pll_clk;

   always @(posedge pll_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor on the falling edge; every handshake pops the scoreboard.
   always @(negedge pll_clk) begin
      if (!rst) begin
         if (frame_err_o) n_ferr++;
         if (overflow_o) n_ovf++;
         if (valid_o) n_valid++;
         if (valid_o && !valid_prev) rise_cyc = cyc;
         if (valid_o && ready_i) begin
            n_pop++;
            if (exp_q.size() != 0) exp_v = 32'(exp_q.pop_front());
            else exp_v = 32'h100;
            check("pop_data", 32'(data_o), 32'(exp_v));
         end
      end
      valid_prev = valid_o;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge pll_clk);
      #1;
   endtask

   task automatic snap();
      s_ferr  = n_ferr;
      s_ovf   = n_ovf;
      s_valid = n_valid;
      s_pop   = n_pop;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      fall_cyc = cyc;
      rx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(CPB);
      end
      rx_i = stop_bit;
      tick(CPB);
   endtask

   initial begin
      rst = 1'b1;
      rx_i = 1'b1;
      ready_i = 1'b0;
      tick(3);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      rst = 1'b0;
      tick(5);

      // Single byte, consumer always ready.
      ready_i = 1'b1;
      snap();
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      tick(5);
      check("single_latency", 32'(rise_cyc), 32'(fall_cyc + 1 + LAT));
      check("single_valid_cycles", 32'(n_valid - s_valid), 32'd1);
      check("single_pops", 32'(n_pop - s_pop), 32'd1);
      check("single_ferr", 32'(n_ferr - s_ferr), 32'd0);
      check("single_ovf", 32'(n_ovf - s_ovf), 32'd0);

      // Back-to-back frames with the consumer stalled: fifth byte overflows.
      ready_i = 1'b0;
      snap();
      exp_q.push_back(8'h00);
      send_byte(8'h00, 1'b1);
      exp_q.push_back(8'hFF);
      send_byte(8'hFF, 1'b1);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1);
      send_byte(8'h55, 1'b1);
      tick(2);
      check("b2b_ovf", 32'(n_ovf - s_ovf), 32'd1);
      check("b2b_ferr", 32'(n_ferr - s_ferr), 32'd0);
      check("b2b_valid", 32'(valid_o), 32'd1);
      check("b2b_head", 32'(data_o), 32'h00);
      ready_i = 1'b1;
      tick(10);
      check("b2b_pops", 32'(n_pop - s_pop), 32'd4);
      check("b2b_drained", 32'(valid_o), 32'd0);

      // Framing error followed by a long break, then a clean byte.
      snap();
      send_byte(8'h12, 1'b0);
      rx_i = 1'b0;
      tick(30 * CPB);
      check("ferr_pulses", 32'(n_ferr - s_ferr), 32'd1);
      check("ferr_no_push", 32'(n_valid - s_valid), 32'd0);
      check("ferr_busy_held", 32'(busy_o), 32'd1);
      rx_i = 1'b1;
      tick(2);
      check("ferr_busy_sync", 32'(busy_o), 32'd1);
      tick(1);
      check("ferr_busy_release", 32'(busy_o), 32'd0);
      tick(20);
      snap();
      exp_q.push_back(8'h34);
      send_byte(8'h34, 1'b1);
      tick(5);
      check("after_ferr_pops", 32'(n_pop - s_pop), 32'd1);
      check("after_ferr_ferr", 32'(n_ferr - s_ferr), 32'd0);

      // Three-cycle glitch on an idle line.
      tick(10);
      snap();
      rx_i = 1'b0;
      tick(3);
      rx_i = 1'b1;
      tick(4);
      check("glitch_busy_before", 32'(busy_o), 32'd1);
      tick(1);
      check("glitch_busy_after", 32'(busy_o), 32'd0);
      tick(100);
      check("glitch_no_push", 32'(n_valid - s_valid), 32'd0);
      check("glitch_no_ferr", 32'(n_ferr - s_ferr), 32'd0);

      // Full FIFO with a pop landing on the cycle of the next push.
      ready_i = 1'b0;
      snap();
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      exp_q.push_back(8'h22);
      send_byte(8'h22, 1'b1);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 1'b1);
      exp_q.push_back(8'h44);
      send_byte(8'h44, 1'b1);
      exp_q.push_back(8'h66);
      fork
         send_byte(8'h66, 1'b1);
         begin
            tick(LAT);
            ready_i = 1'b1;
            tick(1);
            ready_i = 1'b0;
         end
      join
      tick(2);
      check("full_pp_ovf", 32'(n_ovf - s_ovf), 32'd0);
      check("full_pp_pops", 32'(n_pop - s_pop), 32'd1);
      check("full_pp_head", 32'(data_o), 32'h22);
      ready_i = 1'b1;
      tick(10);
      check("full_pp_count", 32'(n_pop - s_pop), 32'd5);
      check("full_pp_drained", 32'(valid_o), 32'd0);

      // Reset in the middle of a frame while a byte is waiting in the FIFO.
      ready_i = 1'b0;
      exp_q.push_back(8'h42);
      send_byte(8'h42, 1'b1);
      tick(2);
      check("pre_rst_valid", 32'(valid_o), 32'd1);
      check("pre_rst_data", 32'(data_o), 32'h42);
      fork
         send_byte(8'h77, 1'b1);
         begin
            tick(5 * CPB + 4);
            check("pre_rst_busy", 32'(busy_o), 32'd1);
            tick(1);
            rst = 1'b1;
            exp_q.delete();
            #1;
            check("mid_rst_valid", 32'(valid_o), 32'd0);
            check("mid_rst_data", 32'(data_o), 32'd0);
            check("mid_rst_busy", 32'(busy_o), 32'd0);
            tick(50);
            rst = 1'b0;
         end
      join
      snap();
      tick(20);
      check("post_rst_no_push", 32'(n_valid - s_valid), 32'd0);
      check("post_rst_no_ferr", 32'(n_ferr - s_ferr), 32'd0);
      ready_i = 1'b1;
      exp_q.push_back(8'h99);
      send_byte(8'h99, 1'b1);
      tick(5);
      check("post_rst_pops", 32'(n_pop - s_pop), 32'd1);
      check("post_rst_ovf", 32'(n_ovf - s_ovf), 32'd0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
